// File: rtl/route_compute_sched_if.sv
// Bundles the buffer-side request/completion lines, the route-compute unit handshake
// and the route table outputs of route_compute_sched.
interface route_compute_sched_if #(
  parameter int unsigned BUFFERS = 5,
  parameter int unsigned OUTPUTS = 5
);
  localparam int unsigned BUF_W = $clog2(BUFFERS);
  localparam int unsigned OUT_W = $clog2(OUTPUTS);

  logic [BUFFERS-1:0]       req;
  logic [BUFFERS-1:0]       pkt_done;
  logic                     rc_start;
  logic [BUF_W-1:0]         rc_buffer_sel;
  logic                     rc_valid;
  logic [OUT_W-1:0]         rc_out_sel;
  logic [BUFFERS-1:0]       route_valid;
  logic [BUFFERS*OUT_W-1:0] route_out;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    input  req, pkt_done, rc_valid, rc_out_sel,
    output rc_start, rc_buffer_sel, route_valid, route_out, busy, timeout_err
  );

  modport slave (
    output req, pkt_done, rc_valid, rc_out_sel,
    input  rc_start, rc_buffer_sel, route_valid, route_out, busy, timeout_err
  );
endinterface

// File: rtl/route_compute_sched.sv
// Round-robin scheduler sharing one route-compute unit among the input buffers;
// keeps a per-buffer route table that is cleared when the packet tail leaves.
module route_compute_sched #(
  parameter int unsigned BUFFERS = 5,
  parameter int unsigned OUTPUTS = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  route_compute_sched_if.master bus
);
  localparam int unsigned BUF_W = $clog2(BUFFERS);
  localparam int unsigned OUT_W = $clog2(OUTPUTS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [BUF_W-1:0]       ptr_q;
  logic [BUF_W-1:0]       sel_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rc_start_q;
  logic                   busy_q;
  logic                   timeout_err_q;
  logic [BUFFERS-1:0]     route_valid_q;
  logic [OUT_W-1:0]       rt_q [BUFFERS];

  logic [BUFFERS-1:0]       elig_c;
  logic [BUF_W-1:0]         pick_c;
  logic [BUF_W-1:0]         ptr_next_c;
  logic [BUFFERS*OUT_W-1:0] route_out_c;

  assign elig_c     = bus.req & ~route_valid_q;
  assign ptr_next_c = (sel_q == BUF_W'(BUFFERS - 1)) ? '0 : sel_q + BUF_W'(1);

  // First eligible buffer at or after the pointer, wrapping by explicit compare
  always_comb begin
    int unsigned idx;
    logic        found;
    pick_c = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < BUFFERS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= BUFFERS) idx = idx - BUFFERS;
      if (!found && elig_c[BUF_W'(idx)]) begin
        pick_c = BUF_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    route_out_c = '0;
    for (int unsigned b = 0; b < BUFFERS; b++) begin
      route_out_c[b*OUT_W +: OUT_W] = rt_q[b];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      rc_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      route_valid_q <= '0;
      for (int unsigned b = 0; b < BUFFERS; b++) rt_q[b] <= '0;
    end else begin
      rc_start_q    <= 1'b0;
      // Tail departures clear entries in every state; a same-cycle latch loses to them
      route_valid_q <= route_valid_q & ~bus.pkt_done;
      case (state_q)
        S_IDLE: begin
          if (|elig_c) begin
            sel_q      <= pick_c;
            rc_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rc_valid) begin
            if (bus.req[sel_q]) begin
              rt_q[sel_q]          <= bus.rc_out_sel;
              route_valid_q[sel_q] <= ~bus.pkt_done[sel_q];
            end
            ptr_q   <= ptr_next_c;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            ptr_q         <= ptr_next_c;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rc_start      = rc_start_q;
  assign bus.rc_buffer_sel = sel_q;
  assign bus.route_valid   = route_valid_q;
  assign bus.route_out     = route_out_c;
  assign bus.busy          = busy_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_route_compute_sched.sv
// Scoreboard bench for route_compute_sched: expected lookups are queued as stimulus
// is applied and checked when the scheduler issues and the route table updates.
module tb_route_compute_sched;
  localparam int unsigned BUFFERS = 5;
  localparam int unsigned OUTPUTS = 5;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    int         sel;
    logic [2:0] out;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [4:0] rv_exp;

  route_compute_sched_if #(.BUFFERS(BUFFERS), .OUTPUTS(OUTPUTS)) bus ();

  route_compute_sched #(
    .BUFFERS(BUFFERS),
    .OUTPUTS(OUTPUTS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req        = '0;
    bus.pkt_done   = '0;
    bus.rc_valid   = 1'b0;
    bus.rc_out_sel = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    rv_exp = '0;
    sb.delete();
  endtask

  // Bounded wait for the issue strobe; an expired budget is a failure
  task automatic wait_issue(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      if (bus.rc_start === 1'b1) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_wait: rc_start=0 after %0d cycles, required 1", n);
    end
  endtask

  // From the ISSUE cycle: answer on the first WAIT cycle, return at the following cycle
  task automatic respond(input logic [2:0] out);
    step();
    bus.rc_valid   = 1'b1;
    bus.rc_out_sel = out;
    step();
    bus.rc_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req        = 5'($urandom);
      bus.pkt_done   = 5'($urandom);
      bus.rc_valid   = 1'($urandom);
      bus.rc_out_sel = 3'($urandom);
      step();
    end
    checks++;
    if ({bus.rc_start, bus.rc_buffer_sel, bus.route_valid, bus.route_out, bus.busy, bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b sel=%0d rv=%b ro=%h busy=%b err=%b, required all 0",
               bus.rc_start, bus.rc_buffer_sel, bus.route_valid, bus.route_out, bus.busy, bus.timeout_err);
    end
    rst = 1'b0;
    idle_inputs();
    rv_exp = '0;
    sb.delete();
  endtask

  task automatic test_single();
    exp_t e;
    bus.req = 5'b00100;
    sb.push_back('{2, 3'd3});
    step();
    e = sb.pop_front();
    checks++;
    if (bus.rc_start !== 1'b1 || bus.rc_buffer_sel !== 3'(e.sel) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: start=%b sel=%0d busy=%b, required 1 %0d 1",
               bus.rc_start, bus.rc_buffer_sel, bus.busy, e.sel);
    end
    respond(e.out);
    rv_exp[e.sel] = 1'b1;
    checks++;
    if (bus.route_valid !== rv_exp || bus.route_out[e.sel*3 +: 3] !== e.out || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_latch: rv=%b ro2=%0d busy=%b, required %b %0d 0",
               bus.route_valid, bus.route_out[e.sel*3 +: 3], bus.busy, rv_exp, e.out);
    end
    step();
    checks++;
    if (bus.rc_start !== 1'b0) begin
      errors++;
      $display("FAIL single_no_reissue: rc_start=%b, required 0", bus.rc_start);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] outs [5];
    exp_t e;
    bit   ok;
    apply_reset();
    outs = '{3'd1, 3'd4, 3'd0, 3'd7, 3'd2};
    bus.req = 5'b11111;
    for (int i = 0; i < 5; i++) sb.push_back('{i, outs[i]});
    for (int i = 0; i < 5; i++) begin
      wait_issue(ok);
      if (!ok) break;
      e = sb.pop_front();
      checks++;
      if (bus.rc_buffer_sel !== 3'(e.sel)) begin
        errors++;
        $display("FAIL rr_order[%0d]: sel=%0d, required %0d", i, bus.rc_buffer_sel, e.sel);
      end
      respond(e.out);
      rv_exp[e.sel] = 1'b1;
      checks++;
      if (bus.route_valid !== rv_exp || bus.route_out[e.sel*3 +: 3] !== e.out) begin
        errors++;
        $display("FAIL rr_latch[%0d]: rv=%b ro=%0d, required %b %0d",
                 i, bus.route_valid, bus.route_out[e.sel*3 +: 3], rv_exp, e.out);
      end
    end
  endtask

  task automatic test_done_reserve();
    exp_t e;
    bit   ok;
    step();
    bus.pkt_done = 5'b00010;
    rv_exp[1]    = 1'b0;
    sb.push_back('{1, 3'd6});
    step();
    bus.pkt_done = '0;
    checks++;
    if (bus.route_valid !== rv_exp) begin
      errors++;
      $display("FAIL done_clear: rv=%b, required %b", bus.route_valid, rv_exp);
    end
    wait_issue(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (bus.rc_buffer_sel !== 3'(e.sel)) begin
        errors++;
        $display("FAIL done_reserve: sel=%0d, required %0d", bus.rc_buffer_sel, e.sel);
      end
      respond(e.out);
      rv_exp[e.sel] = 1'b1;
    end
    // Two tails at once, then wrap from pointer 2 to buffers 4 and 0
    bus.pkt_done = 5'b10001;
    rv_exp       = rv_exp & ~5'b10001;
    sb.push_back('{4, 3'd5});
    sb.push_back('{0, 3'd3});
    step();
    bus.pkt_done = '0;
    checks++;
    if (bus.route_valid !== rv_exp) begin
      errors++;
      $display("FAIL multi_done: rv=%b, required %b", bus.route_valid, rv_exp);
    end
    for (int i = 0; i < 2; i++) begin
      wait_issue(ok);
      if (!ok) break;
      e = sb.pop_front();
      checks++;
      if (bus.rc_buffer_sel !== 3'(e.sel)) begin
        errors++;
        $display("FAIL wrap_order[%0d]: sel=%0d, required %0d", i, bus.rc_buffer_sel, e.sel);
      end
      respond(e.out);
      rv_exp[e.sel] = 1'b1;
    end
    checks++;
    if (bus.route_valid !== rv_exp || bus.route_out[12 +: 3] !== 3'd5 || bus.route_out[0 +: 3] !== 3'd3) begin
      errors++;
      $display("FAIL wrap_table: rv=%b ro=%h, required %b with e4=5 e0=3",
               bus.route_valid, bus.route_out, rv_exp);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    apply_reset();
    bus.req = 5'b00001;
    sb.push_back('{0, 3'd0});
    wait_issue(ok);
    if (!ok) return;
    e = sb.pop_front();
    checks++;
    if (bus.rc_buffer_sel !== 3'(e.sel)) begin
      errors++;
      $display("FAIL to_issue: sel=%0d, required %0d", bus.rc_buffer_sel, e.sel);
    end
    for (int i = 0; i < int'(TIMEOUT); i++) step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_last_wait: err=%b busy=%b, required 0 1", bus.timeout_err, bus.busy);
    end
    step();
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.route_valid !== 5'b00000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_expire: err=%b rv=%b busy=%b, required 1 00000 0",
               bus.timeout_err, bus.route_valid, bus.busy);
    end
    sb.push_back('{0, 3'd2});
    wait_issue(ok);
    if (!ok) return;
    e = sb.pop_front();
    checks++;
    if (bus.rc_buffer_sel !== 3'(e.sel)) begin
      errors++;
      $display("FAIL to_reissue: sel=%0d, required %0d", bus.rc_buffer_sel, e.sel);
    end
    respond(e.out);
    checks++;
    if (bus.route_valid !== 5'b00001 || bus.route_out[0 +: 3] !== e.out || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_recover: rv=%b ro0=%0d err=%b, required 00001 %0d 1",
               bus.route_valid, bus.route_out[0 +: 3], bus.timeout_err, e.out);
    end
  endtask

  task automatic test_withdraw();
    exp_t e;
    bit   ok;
    apply_reset();
    bus.req = 5'b01000;
    sb.push_back('{3, 3'd1});
    wait_issue(ok);
    if (!ok) return;
    e = sb.pop_front();
    checks++;
    if (bus.rc_buffer_sel !== 3'(e.sel)) begin
      errors++;
      $display("FAIL wd_issue: sel=%0d, required %0d", bus.rc_buffer_sel, e.sel);
    end
    step();
    bus.req        = '0;
    bus.rc_valid   = 1'b1;
    bus.rc_out_sel = e.out;
    step();
    bus.rc_valid = 1'b0;
    checks++;
    if (bus.route_valid !== 5'b00000) begin
      errors++;
      $display("FAIL wd_discard: rv=%b, required 00000", bus.route_valid);
    end
    // Pointer must now sit at 4, so 4 is served before 3
    bus.req = 5'b11000;
    sb.push_back('{4, 3'd2});
    sb.push_back('{3, 3'd4});
    for (int i = 0; i < 2; i++) begin
      wait_issue(ok);
      if (!ok) break;
      e = sb.pop_front();
      checks++;
      if (bus.rc_buffer_sel !== 3'(e.sel)) begin
        errors++;
        $display("FAIL wd_ptr[%0d]: sel=%0d, required %0d", i, bus.rc_buffer_sel, e.sel);
      end
      respond(e.out);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    bit   ok;
    apply_reset();
    bus.req = 5'b00100;
    sb.push_back('{2, 3'd4});
    wait_issue(ok);
    if (!ok) return;
    e = sb.pop_front();
    step();
    bus.rc_valid   = 1'b1;
    bus.rc_out_sel = e.out;
    bus.pkt_done   = 5'b00100;
    step();
    bus.rc_valid = 1'b0;
    bus.pkt_done = '0;
    checks++;
    if (bus.route_valid !== 5'b00000) begin
      errors++;
      $display("FAIL collision: rv=%b, required 00000", bus.route_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    apply_reset();
    bus.req = 5'b00010;
    wait_issue(ok);
    if (!ok) return;
    step();
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bus.rc_valid = 1'b1;
    bus.rc_out_sel = 3'd5;
    checks++;
    if (bus.busy !== 1'b0 || bus.route_valid !== 5'b00000 || bus.rc_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_state: busy=%b rv=%b start=%b, required 0 00000 0",
               bus.busy, bus.route_valid, bus.rc_start);
    end
    step();
    checks++;
    if (bus.route_valid !== 5'b00000) begin
      errors++;
      $display("FAIL rst_wait_drop: rv=%b, required 00000", bus.route_valid);
    end
    bus.rc_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rv_exp = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_done_reserve();
    test_timeout();
    test_withdraw();
    test_collision();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
